// File: rtl/dsp_rr_arbiter.sv
// dsp_rr_arbiter: round-robin sharing of one pipelined DSP unit with id-tagged responses
module dsp_rr_arbiter #(
  parameter int width = 32,
  parameter int reqs = 4,
  parameter int latency = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [reqs-1:0]            req_valid,
  input  logic [reqs*width-1:0]      req_a,
  input  logic [reqs*width-1:0]      req_b,
  output logic [reqs-1:0]            req_ready,
  input  logic [reqs-1:0]            mask,
  output logic [width-1:0]           dsp_a,
  output logic [width-1:0]           dsp_b,
  input  logic [width-1:0]           dsp_y,
  output logic                       rsp_valid,
  output logic [$clog2(reqs)-1:0]    rsp_id,
  output logic [width-1:0]           rsp_y,
  output logic [7:0]                 inflight,
  output logic                       idle
);
  localparam int idw = $clog2(reqs);
  logic [reqs-1:0] elig;
  logic [idw-1:0] ptr, g, k;
  logic hit, accept;
  int idx;
  logic [latency:0] tag_v;
  logic [idw-1:0] tag_id [latency+1];
  // first eligible requester searching upward from ptr with wrap-around
  always_comb begin
    elig = req_valid & mask;
    hit = 1'b0;
    g = '0;
    idx = 0;
    k = '0;
    for (int i = 0; i < reqs; i++) begin
      idx = (int'(ptr) + i) % reqs;
      k = idw'(idx);
      if (!hit && elig[k]) begin
        hit = 1'b1;
        g = k;
      end
    end
    accept = hit && !reset;
    req_ready = accept ? reqs'(1) << g : '0;
  end
  // register granted operands onto the DSP and advance the round-robin pointer
  always_ff @(posedge clock)
    if (reset) begin
      ptr <= '0;
      dsp_a <= '0;
      dsp_b <= '0;
    end else begin
      ptr <= accept ? (g == idw'(reqs - 1) ? '0 : g + 1'b1) : ptr;
      dsp_a <= accept ? req_a[g*width +: width] : '0;
      dsp_b <= accept ? req_b[g*width +: width] : '0;
    end
  // tag pipe tracks the requester id alongside the DSP pipeline, one slot per cycle
  always_ff @(posedge clock)
    if (reset) begin
      tag_v <= '0;
      for (int s = 0; s <= latency; s++) tag_id[s] <= '0;
    end else begin
      tag_v <= {tag_v[latency-1:0], accept};
      tag_id[0] <= g;
      for (int s = 1; s <= latency; s++) tag_id[s] <= tag_id[s-1];
    end
  // capture the DSP result when its tag leaves the pipe; hold it otherwise
  always_ff @(posedge clock)
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_y <= '0;
    end else begin
      rsp_valid <= tag_v[latency];
      if (tag_v[latency]) begin
        rsp_id <= tag_id[latency];
        rsp_y <= dsp_y;
      end
    end
  // count operations accepted but not yet emitted as responses
  always_ff @(posedge clock)
    if (reset) inflight <= '0;
    else inflight <= inflight + 8'(accept) - 8'(rsp_valid);
  assign idle = inflight == 8'd0;
endmodule

// File: doc/dsp_rr_arbiter.md
# dsp_rr_arbiter

Round-robin arbiter that shares one pipelined DSP arithmetic unit (`dsp_add`, `dsp_mul` or one lane of a vector variant) among `reqs` requesters. It accepts at most one operand pair per cycle under a valid/ready handshake and registers the pair onto the DSP inputs. It tracks each operation's requester id through a tag pipeline matched to the DSP latency, and returns each registered result tagged with its id. The block sits between requester datapaths and the shared DSP instance, which is external and connected through the `dsp_*` ports.

## Interface
- `width`, 32: operand/result width in bits.
- `reqs`, 4: number of requesters, 2..8.
- `latency`, 2: DSP pipeline latency in cycles, ≥1. `dsp_y` reflects the `dsp_a`/`dsp_b` values presented `latency` cycles earlier.

- `clock` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in `reqs`: per-requester request.
- `req_a` in `reqs*width`: operand a of requester i is `[i*width +: width]`.
- `req_b` in `reqs*width`: operand b, same packing as `req_a`.
- `req_ready` out `reqs`: one-hot grant; zero when nothing is granted.
- `mask` in `reqs`: requester enable; a requester with its bit at 0 is never granted.
- `dsp_a` out `width`: registered operand a to the DSP unit.
- `dsp_b` out `width`: registered operand b to the DSP unit.
- `dsp_y` in `width`: DSP result.
- `rsp_valid` out 1: response strobe, one cycle per operation.
- `rsp_id` out `$clog2(reqs)`: requester id of the response.
- `rsp_y` out `width`: registered result.
- `inflight` out 8: number of accepted operations whose response has not yet been emitted.
- `idle` out 1: high when `inflight == 0`.

## Operation
- **Grant logic** (combinational):
  - The eligible set is `req_valid & mask`.
  - Search eligible requesters in order `ptr, ptr+1, …, reqs-1, 0, …, ptr-1`; the first hit `g` gets `req_ready[g]=1`.
  - `req_ready` depends on `req_valid`; requesters must not make `req_valid` depend on `req_ready`.
  - During reset, `req_ready` is all zero.
- **Acceptance** happens when `req_valid[g] & req_ready[g]` at a rising edge. On acceptance:
  - `dsp_a <= req_a[g]` and `dsp_b <= req_b[g]`.
  - `ptr <= (g+1) mod reqs`, which wraps from `reqs-1` to 0.
  - A tag `{1, g}` is pushed into stage 0 of the tag pipe.
- **No acceptance** in a cycle:
  - `dsp_a` and `dsp_b` are driven to 0.
  - A tag `{0, x}` is pushed.
  - `ptr` holds.
- **Tag pipe**: `latency+1` stages, shifting every cycle with no stall. When the tag leaving the last stage is valid: `rsp_valid <= 1`, `rsp_id <= tag id`, `rsp_y <= dsp_y`. Otherwise `rsp_valid <= 0` and `rsp_y`/`rsp_id` hold their values.
- **`inflight`** changes by +1 on accept and −1 on response emit; a simultaneous accept and emit leaves it unchanged. Maximum value is `latency+2`, so it never saturates.
- **Arithmetic**: the block performs none. `rsp_y` equals `dsp_y` bit-for-bit, modulo 2^width as produced by the DSP.
- **Mask** changes take effect in the same cycle. Operations already accepted complete normally regardless of mask.
- **Responses have no backpressure**. Requesters sink `rsp_valid` unconditionally.

## Timing
- **Reset values**: `ptr=0`; `dsp_a=0`, `dsp_b=0`; all tags invalid; `rsp_valid=0`, `rsp_id=0`, `rsp_y=0`; `inflight=0`; `idle=1`; `req_ready=0`.
- **Latency**: for a handshake in cycle c:
  - `dsp_a`/`dsp_b` carry the operands in cycle c+1.
  - `dsp_y` is valid in cycle c+1+latency.
  - `rsp_valid` is high in cycle c+2+latency.
  - Total latency is `latency+2` cycles.
- **Throughput**: one accept per cycle. Back-to-back accepts produce back-to-back responses in accept order.
- **Reset mid-operation**: all in-flight tags are discarded, so no `rsp_valid` is ever produced for them. `inflight=0` in the first cycle after reset deasserts.
- **Simultaneous events**:
  - Accept and response in the same cycle are independent.
  - Among several eligible requesters, only the first in round-robin order from `ptr` is granted; the others wait with `req_ready=0`.

## Test plan
Bench setup: `width=32`, `reqs=4`, `latency=2`, behavioural 2-stage adder as the DSP, `mask=4'b1111` unless stated, reset high in cycles 0–1.

1. Single request: `req_valid[1]=1` with `a=32'd1`, `b=32'hffff0001` in cycle 3 → `req_ready=4'b0010` in cycle 3; `dsp_a=1` in cycle 4; `rsp_valid=1`, `rsp_id=1`, `rsp_y=32'hffff0002` in cycle 7 only; `idle` back to 1 in cycle 8.
2. All four requesters valid continuously from cycle 2 → grants 0,1,2,3,0,1,… one per cycle; responses back-to-back from cycle 6 with `rsp_id` 0,1,2,3,…; `inflight` steady at 4.
3. `mask=4'b1010` with all four valid → grants alternate 1,3,1,3; `req_ready[0]` and `req_ready[2]` never high.
4. Wrap-around: after a grant to requester 3, only requesters 0 and 2 valid → grant 0, then 2, then 0.
5. Reset mid-operation: accepts in cycles 3 and 4, then `reset=1` in cycle 5 → no `rsp_valid` through cycle 12; `inflight=0`, `idle=1`, and next grant starts from requester 0.
6. Gapped traffic: requester 2 with `a=-32'd255`, `b=32'd3` in cycle 2 and again in cycle 5 → `dsp_a=0` in cycles 4–5; responses in cycles 6 and 9 with `rsp_y=32'hffffff04`; `rsp_y` holds between them.
